vga_pixel_output: RTL and testbench



---
 rtl/vga_pixel_output.sv | 129 ++++++++++++
 tb/tb_vga_pixel_output.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vga_pixel_output.sv
// VGA 640x480@60 raster generator and pixel sink: publishes the pixel coordinate, expands RRRGGGBB
// input to 4-4-4 DAC levels and emits blanking and sync delay-matched to the returned pixel.
module vga_pixel_output #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  RGBIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hsyncN,
    output logic        vsyncN
);

    localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST     = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] h_count_r;
    logic [10:0] v_count_r;
    logic        active_s;
    logic        hs_s;
    logic        vs_s;
    logic        active_d_s;
    logic        hs_d_s;
    logic        vs_d_s;

    // Widen RRRGGGBB to 4-4-4 by replicating the top bits so full scale maps to 4'hF.
    function automatic logic [11:0] expand_rgb(input logic [7:0] pix);
        expand_rgb = {pix[7:5], pix[7], pix[4:2], pix[4], pix[1:0], pix[1:0]};
    endfunction

    // Raster counters; both wrap together at the last pixel of the last line.
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count_r <= 11'd0;
            v_count_r <= 11'd0;
        end else if (h_count_r == H_LAST) begin
            h_count_r <= 11'd0;
            if (v_count_r == V_LAST) begin
                v_count_r <= 11'd0;
            end else begin
                v_count_r <= v_count_r + 11'd1;
            end
        end else begin
            h_count_r <= h_count_r + 11'd1;
        end
    end

    assign pixelX       = h_count_r;
    assign pixelY       = v_count_r;
    assign startOfFrame = (h_count_r == 11'd0) && (v_count_r == 11'd0);

    assign active_s = (h_count_r < H_ACT) && (v_count_r < V_ACT);
    assign hs_s     = (h_count_r >= HS_FIRST) && (h_count_r <= HS_LAST);
    assign vs_s     = (v_count_r >= VS_FIRST) && (v_count_r <= VS_LAST);

    // Flags travel alongside the upstream pixel pipeline so they line up with RGBIn.
    generate
        if (PIPE_DELAY == 0) begin : g_no_delay
            assign active_d_s = active_s;
            assign hs_d_s     = hs_s;
            assign vs_d_s     = vs_s;
        end else begin : g_delay
            logic [PIPE_DELAY-1:0] active_pipe_r;
            logic [PIPE_DELAY-1:0] hs_pipe_r;
            logic [PIPE_DELAY-1:0] vs_pipe_r;

            // Flag shift register, cleared on reset so no stale pixel or sync escapes.
            always_ff @(posedge clk) begin
                if (reset) begin
                    active_pipe_r <= '0;
                    hs_pipe_r     <= '0;
                    vs_pipe_r     <= '0;
                end else begin
                    active_pipe_r[0] <= active_s;
                    hs_pipe_r[0]     <= hs_s;
                    vs_pipe_r[0]     <= vs_s;
                    for (int i = 1; i < PIPE_DELAY; i++) begin
                        active_pipe_r[i] <= active_pipe_r[i-1];
                        hs_pipe_r[i]     <= hs_pipe_r[i-1];
                        vs_pipe_r[i]     <= vs_pipe_r[i-1];
                    end
                end
            end

            assign active_d_s = active_pipe_r[PIPE_DELAY-1];
            assign hs_d_s     = hs_pipe_r[PIPE_DELAY-1];
            assign vs_d_s     = vs_pipe_r[PIPE_DELAY-1];
        end
    endgenerate

    // DAC output register: expanded colour in the active area, black in blanking, sync alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            red    <= 4'h0;
            green  <= 4'h0;
            blue   <= 4'h0;
            hsyncN <= 1'b1;
            vsyncN <= 1'b1;
        end else begin
            if (active_d_s) begin
                {red, green, blue} <= expand_rgb(RGBIn);
            end else begin
                {red, green, blue} <= 12'h000;
            end
            hsyncN <= ~hs_d_s;
            vsyncN <= ~vs_d_s;
        end
    end

endmodule

// File: tb/tb_vga_pixel_output.sv
// Scoreboard bench for vga_pixel_output: the driver queues the expected output of each cycle,
// a negedge monitor pops and compares. Vertical timing is shortened so a full frame fits the run.
module tb_vga_pixel_output;

    localparam int H_TOTAL  = 800;
    localparam int TB_V_ACT = 8;
    localparam int TB_V_FP  = 2;
    localparam int TB_V_SYN = 2;
    localparam int TB_V_BP  = 3;
    localparam int V_TOTAL  = TB_V_ACT + TB_V_FP + TB_V_SYN + TB_V_BP;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs_n;
        logic        vs_n;
        logic [10:0] x;
        logic [10:0] y;
        logic        sof;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  RGBIn = 8'h00;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        hsyncN;
    logic        vsyncN;

    rec_t q[$];
    bit   mon_en = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    // Hand-computed expansions of the directed colour vectors.
    logic [7:0]  pat_in  [6] = '{8'hE0, 8'h03, 8'h56, 8'hFF, 8'h1C, 8'h92};
    logic [11:0] pat_exp [6] = '{12'hF00, 12'h00F, 12'h4BA, 12'hFFF, 12'h0F0, 12'h99A};

    vga_pixel_output #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(TB_V_ACT), .V_FP(TB_V_FP), .V_SYNC(TB_V_SYN), .V_BP(TB_V_BP),
        .PIPE_DELAY(1)
    ) dut (
        .clk(clk), .reset(reset), .RGBIn(RGBIn),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .red(red), .green(green), .blue(blue),
        .hsyncN(hsyncN), .vsyncN(vsyncN)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int n);
        pat = (n < 1600) ? pat_in[n % 6] : 8'hFF;
    endfunction

    function automatic logic [11:0] pat_color(input int n);
        pat_color = (n < 1600) ? pat_exp[n % 6] : 12'hFFF;
    endfunction

    function automatic rec_t reset_rec();
        rec_t r;
        r.rgb = 12'h000; r.hs_n = 1'b1; r.vs_n = 1'b1;
        r.x = 11'd0; r.y = 11'd0; r.sof = 1'b1;
        return r;
    endfunction

    // Expected output in cycle m, given RGBIn driven during cycle n = m-1 and the raster at m-2.
    function automatic rec_t model_rec(input int m, input int n);
        rec_t r;
        int k;
        int kx;
        int ky;
        k  = n - 1;
        kx = (k >= 0) ? (k % H_TOTAL) : -1;
        ky = (k >= 0) ? ((k / H_TOTAL) % V_TOTAL) : -1;
        r.rgb  = (k >= 0 && kx < 640 && ky < TB_V_ACT) ? pat_color(n) : 12'h000;
        r.hs_n = !(k >= 0 && kx >= 656 && kx <= 751);
        r.vs_n = !(k >= 0 && ky >= TB_V_ACT + TB_V_FP && ky <= TB_V_ACT + TB_V_FP + TB_V_SYN - 1);
        r.x    = 11'(m % H_TOTAL);
        r.y    = 11'((m / H_TOTAL) % V_TOTAL);
        r.sof  = (r.x == 11'd0) && (r.y == 11'd0);
        return r;
    endfunction

    task automatic run(input int ncyc, input bit reset_at_end);
        for (int n = 0; n < ncyc; n++) begin
            RGBIn = pat(n);
            if (reset_at_end && n == ncyc - 1) begin
                reset = 1'b1;
                q.push_back(reset_rec());
            end else begin
                q.push_back(model_rec(n + 1, n));
            end
            @(posedge clk);
            #1;
        end
        if (reset_at_end) reset = 1'b0;
    endtask

    // Monitor: one expected record per output cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            rec_t e;
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL underflow at %0t: no expected record queued", $time);
            end else begin
                e = q.pop_front();
                if ({red, green, blue} !== e.rgb) begin
                    miscompares++;
                    $display("FAIL color at %0t (x=%0d y=%0d): got %h want %h",
                             $time, pixelX, pixelY, {red, green, blue}, e.rgb);
                end
                vectors++;
                if ({hsyncN, vsyncN} !== {e.hs_n, e.vs_n}) begin
                    miscompares++;
                    $display("FAIL sync at %0t (x=%0d y=%0d): got hs=%b vs=%b want hs=%b vs=%b",
                             $time, pixelX, pixelY, hsyncN, vsyncN, e.hs_n, e.vs_n);
                end
                vectors++;
                if ({pixelX, pixelY, startOfFrame} !== {e.x, e.y, e.sof}) begin
                    miscompares++;
                    $display("FAIL coord at %0t: got (%0d,%0d,sof=%b) want (%0d,%0d,sof=%b)",
                             $time, pixelX, pixelY, startOfFrame, e.x, e.y, e.sof);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        q.push_back(reset_rec());
        mon_en = 1'b1;
        // Line 0 with colour vectors, then reset while hsyncN is low at hCount=700.
        run(701, 1'b1);
        // Full shortened frame plus part of the next, RGBIn held at FF after two lines.
        run(V_TOTAL * H_TOTAL + 1000, 1'b0);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: got %0d queued records want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
